// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C sensor configuration sequencer.
// The optional WAIT watchdog is enabled by defining CFG_WATCHDOG_EN.
package i2c_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_WAIT,
      ST_NEXT,
      ST_RETRY,
      ST_SKIP,
      ST_SERVE
   } seq_state_e;

   localparam int unsigned WDOG_TICKS  = 1024;
   localparam int unsigned ERR_CNT_MAX = 255;

   // Bits needed to hold the divider terminal count CLK_FREQ/I2C_FREQ-1.
   function automatic int unsigned div_width(input int unsigned clk_freq,
                                             input int unsigned i2c_freq);
      int unsigned ratio;
      int unsigned w;
      ratio = (i2c_freq == 0 || clk_freq < i2c_freq) ? 1 : clk_freq / i2c_freq;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if (((ratio - 1) >> i) != 0) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_FREQ/I2C_FREQ cycles.
module i2c_tick_gen
   import i2c_cfg_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned I2C_FREQ = 20000
)(
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int unsigned RATIO = (I2C_FREQ == 0 || CLK_FREQ < I2C_FREQ) ? 1 : CLK_FREQ / I2C_FREQ;
   localparam int unsigned DW    = div_width(CLK_FREQ, I2C_FREQ);
   localparam logic [DW-1:0] TOP = DW'(RATIO - 1);

   logic [DW-1:0] div_q, div_d;

   assign tick_o = (div_q == TOP);

   always_comb begin
      div_d = tick_o ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) div_q <= '0;
      else         div_q <= div_d;
   end

endmodule

// File: rtl/i2c_sensor_cfg_seq.sv
// Register-table write sequencer with NACK retry/skip and post-table update service.
// Define CFG_WATCHDOG_EN to bound WAIT at WDOG_TICKS ticks (timeout handled as a NACK).
module i2c_sensor_cfg_seq
   import i2c_cfg_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned I2C_FREQ  = 20000,
   parameter logic [7:0]  DEV_ADDR  = 8'hBA,
   parameter int unsigned REG_AW    = 8,
   parameter int unsigned REG_DW    = 16,
   parameter int unsigned LUT_SIZE  = 25,
   parameter int unsigned MAX_RETRY = 3
)(
   input  logic                           iCLK,
   input  logic                           iRST_N,
   input  logic                           iRESTART,
   output logic [7:0]                     oLUT_INDEX,
   input  logic [REG_AW+REG_DW-1:0]       iLUT_DATA,
   input  logic                           iUPD_REQ,
   input  logic [REG_AW-1:0]              iUPD_ADDR,
   input  logic [REG_DW-1:0]              iUPD_DATA,
   output logic                           oUPD_ACK,
   output logic                           oI2C_TICK,
   output logic [8+REG_AW+REG_DW-1:0]     oI2C_DATA,
   output logic                           oI2C_GO,
   input  logic                           iI2C_END,
   input  logic                           iI2C_ACK,
   output logic                           oCFG_DONE,
   output logic                           oBUSY,
   output logic                           oERR,
   output logic [7:0]                     oERR_CNT
);

   localparam int unsigned XW = 8 + REG_AW + REG_DW;

   seq_state_e          state_q, state_d;
   logic [7:0]          idx_q, idx_d;
   logic [XW-1:0]       data_q, data_d;
   logic                go_q, go_d;
   logic [3:0]          retry_q, retry_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic                pend_q, pend_d;
   logic [REG_AW-1:0]   uaddr_q, uaddr_d;
   logic [REG_DW-1:0]   udata_q, udata_d;
   logic                ack_q, ack_d;
   logic                restart_q, restart_d;
   logic                fin, nack;
`ifdef CFG_WATCHDOG_EN
   logic [9:0]          wd_q, wd_d;
`endif

   i2c_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .I2C_FREQ (I2C_FREQ)
   ) u_tick (
      .clk_i  (iCLK),
      .rst_ni (iRST_N),
      .tick_o (oI2C_TICK)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
      go_d      = go_q;
      retry_d   = retry_q;
      done_d    = done_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      pend_d    = pend_q;
      uaddr_d   = uaddr_q;
      udata_d   = udata_q;
      ack_d     = 1'b0;
      restart_d = restart_q | iRESTART;
      fin       = 1'b0;
      nack      = 1'b0;
`ifdef CFG_WATCHDOG_EN
      wd_d      = wd_q;
`endif

      // Update capture runs every cycle, independent of the tick.
      if (iUPD_REQ && !pend_q) begin
         uaddr_d = iUPD_ADDR;
         udata_d = iUPD_DATA;
         pend_d  = 1'b1;
         ack_d   = 1'b1;
      end

      if (iRESTART) go_d = 1'b0;

      if (oI2C_TICK) begin
         if (restart_q || iRESTART) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            done_d    = 1'b0;
            go_d      = 1'b0;
            restart_d = 1'b0;
         end else begin
            case (state_q)
               ST_IDLE:  state_d = ST_LOAD;
               ST_LOAD: begin
                  data_d  = done_q ? {DEV_ADDR, uaddr_q, udata_q} : {DEV_ADDR, iLUT_DATA};
                  retry_d = '0;
                  state_d = ST_SEND;
               end
               ST_SEND: begin
                  go_d    = 1'b1;
`ifdef CFG_WATCHDOG_EN
                  wd_d    = '0;
`endif
                  state_d = ST_WAIT;
               end
               ST_WAIT: begin
                  fin  = iI2C_END;
                  nack = iI2C_ACK;
`ifdef CFG_WATCHDOG_EN
                  if (!iI2C_END) begin
                     if (wd_q == 10'(WDOG_TICKS - 1)) begin
                        fin  = 1'b1;
                        nack = 1'b1;
                     end else begin
                        wd_d = wd_q + 1'b1;
                     end
                  end
`endif
                  if (fin) begin
                     go_d = 1'b0;
                     if (!nack) begin
                        state_d = ST_NEXT;
                     end else if (retry_q < 4'(MAX_RETRY)) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_RETRY;
                     end else begin
                        state_d = ST_SKIP;
                     end
                  end
               end
               ST_RETRY: state_d = ST_SEND;
               // SKIP records the error and then advances exactly like NEXT.
               ST_NEXT, ST_SKIP: begin
                  if (state_q == ST_SKIP) begin
                     err_d = 1'b1;
                     if (err_cnt_q != 8'(ERR_CNT_MAX)) err_cnt_d = err_cnt_q + 8'd1;
                  end
                  if (done_q) begin
                     pend_d  = 1'b0;
                     state_d = ST_SERVE;
                  end else if (idx_q < 8'(LUT_SIZE - 1)) begin
                     idx_d   = idx_q + 8'd1;
                     state_d = ST_LOAD;
                  end else begin
                     done_d  = 1'b1;
                     state_d = ST_SERVE;
                  end
               end
               ST_SERVE: if (pend_q) state_d = ST_LOAD;
               default:  state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         data_q    <= {DEV_ADDR, {(REG_AW+REG_DW){1'b0}}};
         go_q      <= 1'b0;
         retry_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         pend_q    <= 1'b0;
         uaddr_q   <= '0;
         udata_q   <= '0;
         ack_q     <= 1'b0;
         restart_q <= 1'b0;
`ifdef CFG_WATCHDOG_EN
         wd_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         go_q      <= go_d;
         retry_q   <= retry_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         pend_q    <= pend_d;
         uaddr_q   <= uaddr_d;
         udata_q   <= udata_d;
         ack_q     <= ack_d;
         restart_q <= restart_d;
`ifdef CFG_WATCHDOG_EN
         wd_q      <= wd_d;
`endif
      end
   end

   assign oLUT_INDEX = idx_q;
   assign oI2C_DATA  = data_q;
   assign oI2C_GO    = go_q;
   assign oUPD_ACK   = ack_q;
   assign oCFG_DONE  = done_q;
   assign oERR       = err_q;
   assign oERR_CNT   = err_cnt_q;
   assign oBUSY      = (state_q == ST_SEND) || (state_q == ST_WAIT) || (state_q == ST_RETRY);

endmodule

// File: tb/tb_i2c_sensor_cfg_seq.sv
// Randomized bench: a write-list model built from the table/retry rules is
// compared against every transfer the sequencer issues.
module tb_i2c_sensor_cfg_seq;

   localparam int unsigned LUT_SIZE  = 4;
   localparam int unsigned MAX_RETRY = 3;

   logic        iCLK = 1'b0;
   logic        iRST_N;
   logic        iRESTART;
   logic [7:0]  oLUT_INDEX;
   logic [23:0] iLUT_DATA;
   logic        iUPD_REQ;
   logic [7:0]  iUPD_ADDR;
   logic [15:0] iUPD_DATA;
   logic        oUPD_ACK;
   logic        oI2C_TICK;
   logic [31:0] oI2C_DATA;
   logic        oI2C_GO;
   logic        iI2C_END;
   logic        iI2C_ACK;
   logic        oCFG_DONE;
   logic        oBUSY;
   logic        oERR;
   logic [7:0]  oERR_CNT;

   logic [23:0] lut [LUT_SIZE];
   assign iLUT_DATA = lut[oLUT_INDEX[1:0]];

   i2c_sensor_cfg_seq #(
      .CLK_FREQ  (1000),
      .I2C_FREQ  (250),
      .DEV_ADDR  (8'hBA),
      .REG_AW    (8),
      .REG_DW    (16),
      .LUT_SIZE  (LUT_SIZE),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .iCLK       (iCLK),
      .iRST_N     (iRST_N),
      .iRESTART   (iRESTART),
      .oLUT_INDEX (oLUT_INDEX),
      .iLUT_DATA  (iLUT_DATA),
      .iUPD_REQ   (iUPD_REQ),
      .iUPD_ADDR  (iUPD_ADDR),
      .iUPD_DATA  (iUPD_DATA),
      .oUPD_ACK   (oUPD_ACK),
      .oI2C_TICK  (oI2C_TICK),
      .oI2C_DATA  (oI2C_DATA),
      .oI2C_GO    (oI2C_GO),
      .iI2C_END   (iI2C_END),
      .iI2C_ACK   (iI2C_ACK),
      .oCFG_DONE  (oCFG_DONE),
      .oBUSY      (oBUSY),
      .oERR       (oERR),
      .oERR_CNT   (oERR_CNT)
   );

   always #5 iCLK = ~iCLK;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_data [$];
   bit          exp_nack [$];
   int          exp_total, exp_err, upd1_end;
   int          started, ended;
   bit          hang_en, hanging, active, cur_nack;
   int          cd;
   logic [31:0] cur_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // A write NACKed k times succeeds after k+1 attempts, or is skipped after MAX_RETRY+1.
   task automatic push_write(input logic [31:0] data, input int k);
      int att;
      att = (k > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : k + 1;
      for (int j = 0; j < att; j++) begin
         exp_data.push_back(data);
         exp_nack.push_back(j < k);
      end
      if (k > int'(MAX_RETRY)) exp_err++;
   endtask

   task automatic build(input int n, input bit directed, input bit with_upd,
                        input logic [7:0] a1, input logic [15:0] d1,
                        input logic [7:0] a2, input logic [15:0] d2);
      int dir_k [LUT_SIZE] = '{0, 2, 4, 0};
      exp_data.delete();
      exp_nack.delete();
      for (int i = 0; i < n; i++)
         push_write({8'hBA, lut[i]}, directed ? dir_k[i] : int'($urandom_range(0, 5)));
      if (with_upd) begin
         push_write({8'hBA, a1, d1}, int'($urandom_range(0, 5)));
         upd1_end = exp_data.size();
         push_write({8'hBA, a2, d2}, int'($urandom_range(0, 5)));
      end
      exp_total = exp_data.size();
      started   = 0;
      ended     = 0;
   endtask

   task automatic wait_tick();
      do @(negedge iCLK); while (!oI2C_TICK);
   endtask

   task automatic pulse_restart();
      wait_tick();
      @(negedge iCLK);
      iRESTART = 1'b1;
      @(negedge iCLK);
      iRESTART = 1'b0;
      check("restart_go_drop", oI2C_GO, 0);
      wait_tick();
      @(negedge iCLK);
      check("restart_done_clr", oCFG_DONE, 0);
      check("restart_idx_clr", oLUT_INDEX, 0);
      check("restart_errcnt_kept", oERR_CNT, exp_err);
   endtask

   task automatic wait_done();
      int c;
      for (c = 0; c < 20000 && ended != exp_total; c++) @(negedge iCLK);
      if (c >= 20000) check("round_timeout", ended, exp_total);
      repeat (2) wait_tick();
      @(negedge iCLK);
      check("xfer_count", started, exp_total);
      check("cfg_done", oCFG_DONE, 1);
      check("busy_idle", oBUSY, 0);
      check("go_idle", oI2C_GO, 0);
      check("idx_final", oLUT_INDEX, LUT_SIZE - 1);
      check("err_cnt", oERR_CNT, exp_err);
      check("err_flag", oERR, exp_err != 0);
   endtask

   task automatic requester(input logic [7:0] a1, input logic [15:0] d1,
                            input logic [7:0] a2, input logic [15:0] d2);
      int c;
      repeat ($urandom_range(1, 4)) wait_tick();
      @(negedge iCLK);
      iUPD_ADDR = a1; iUPD_DATA = d1; iUPD_REQ = 1'b1;
      @(negedge iCLK);
      check("upd1_ack", oUPD_ACK, 1);
      check("upd1_during_table", oCFG_DONE, 0);
      iUPD_REQ = 1'b0;
      @(negedge iCLK);
      check("upd1_ack_pulse", oUPD_ACK, 0);
      iUPD_ADDR = a2; iUPD_DATA = d2; iUPD_REQ = 1'b1;
      for (c = 0; c < 20000 && !oUPD_ACK; c++) @(negedge iCLK);
      check("upd2_held_until_upd1", (c < 20000) && (ended >= upd1_end), 1);
      iUPD_REQ = 1'b0;
   endtask

   task automatic rand_lut();
      for (int i = 0; i < LUT_SIZE; i++) lut[i] = 24'($urandom);
   endtask

   // Byte-level controller: END is a one-cycle pulse on a tick cycle.
   initial begin
      iI2C_END = 1'b0; iI2C_ACK = 1'b0;
      active = 0; hanging = 0; cd = 0; cur_nack = 0; cur_data = '0;
      forever begin
         @(negedge iCLK);
         if (iI2C_END) iI2C_END = 1'b0;
         if (iRST_N && oI2C_TICK) begin
            if (active && !oI2C_GO) begin
               active = 0; hanging = 0;
            end else if (!active && oI2C_GO) begin
               active = 1;
               if (hang_en && oLUT_INDEX == 8'(LUT_SIZE - 1) && !oCFG_DONE) begin
                  hanging = 1;
               end else begin
                  started++;
                  cur_nack = 0;
                  if (exp_data.size() > 0) begin
                     check("xfer_data", oI2C_DATA, exp_data.pop_front());
                     cur_nack = exp_nack.pop_front();
                  end
                  cur_data = oI2C_DATA;
                  cd = int'($urandom_range(0, 2));
               end
            end else if (active && !hanging) begin
               cd--;
            end
            if (active && !hanging && cd <= 0) begin
               check("data_stable", oI2C_DATA, cur_data);
               iI2C_END = 1'b1;
               iI2C_ACK = cur_nack;
               active = 0;
               ended++;
            end
         end
      end
   end

   initial begin
      int c;
      logic [7:0]  a1, a2;
      logic [15:0] d1, d2;
      iRST_N = 1'b0; iRESTART = 1'b0; iUPD_REQ = 1'b0; iUPD_ADDR = '0; iUPD_DATA = '0;
      hang_en = 0; exp_err = 0; upd1_end = 0;
      rand_lut();
      repeat (3) @(negedge iCLK);
      check("rst_go", oI2C_GO, 0);
      check("rst_done", oCFG_DONE, 0);
      check("rst_busy", oBUSY, 0);
      check("rst_err", oERR, 0);
      check("rst_errcnt", oERR_CNT, 0);
      check("rst_idx", oLUT_INDEX, 0);
      check("rst_data", oI2C_DATA, 32'hBA00_0000);
      check("rst_ack", oUPD_ACK, 0);
      check("rst_tick", oI2C_TICK, 0);

      // Round 0: directed NACK pattern (retry-then-ok, skip) plus two updates.
      build(LUT_SIZE, 1, 1, 8'h09, 16'h0500, 8'h0A, 16'h1234);
      iRST_N = 1'b1;
      fork
         requester(8'h09, 16'h0500, 8'h0A, 16'h1234);
         wait_done();
      join

      // Round 1: random table and updates, started by a restart from SERVE.
      rand_lut();
      pulse_restart();
      a1 = 8'($urandom); a2 = 8'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
      build(LUT_SIZE, 0, 1, a1, d1, a2, d2);
      fork
         requester(a1, d1, a2, d2);
         wait_done();
      join

      // Round 2: controller stalls on the last entry; restart mid-WAIT re-runs the table.
      rand_lut();
      pulse_restart();
      build(LUT_SIZE - 1, 0, 0, '0, '0, '0, '0);
      hang_en = 1;
      for (c = 0; c < 20000 && !hanging; c++) @(negedge iCLK);
      check("hang_reached", hanging, 1);
      repeat (2) wait_tick();
      check("hang_go_high", oI2C_GO, 1);
      check("hang_busy", oBUSY, 1);
      hang_en = 0;
      pulse_restart();
      build(LUT_SIZE, 0, 0, '0, '0, '0, '0);
      wait_done();

      // Round 3: plain random table.
      rand_lut();
      pulse_restart();
      build(LUT_SIZE, 0, 0, '0, '0, '0, '0);
      wait_done();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_sensor_cfg_seq.md
# i2c_sensor_cfg_seq

Parametrised I2C register-write sequencer for CMOS sensor bring-up and run-time tuning. It walks a register table supplied on a ROM-style port and issues one write per entry to a byte-level I2C write controller. NACKed writes are retried a bounded number of times before they are skipped. After the table finishes, it serves single-register update requests (exposure, gain, window) without a full re-sequence.

## Interface
Parameters:
- CLK_FREQ, 50000000, iCLK frequency in Hz
- I2C_FREQ, 20000, controller tick rate in Hz; tick period = CLK_FREQ/I2C_FREQ cycles
- DEV_ADDR, 8'hBA, 8-bit device write address
- REG_AW, 8, register sub-address width
- REG_DW, 16, register data width
- LUT_SIZE, 25, number of table entries (1..256)
- MAX_RETRY, 3, retries per write after the first NACK (0..15)

Ports:
- iCLK, in, 1, system clock
- iRST_N, in, 1, reset; asynchronous, active-low
- iRESTART, in, 1, one-cycle pulse that re-runs the table from index 0
- oLUT_INDEX, out, 8, table index being fetched
- iLUT_DATA, in, REG_AW+REG_DW, {addr,data}; combinational from oLUT_INDEX
- iUPD_REQ, in, 1, update request; held until oUPD_ACK
- iUPD_ADDR, in, REG_AW, update register address
- iUPD_DATA, in, REG_DW, update value
- oUPD_ACK, out, 1, one-cycle pulse when the update is latched
- oI2C_TICK, out, 1, one-cycle controller enable at I2C_FREQ
- oI2C_DATA, out, 8+REG_AW+REG_DW, {DEV_ADDR,addr,data}
- oI2C_GO, out, 1, transfer request level
- iI2C_END, in, 1, transfer complete; sampled on ticks only
- iI2C_ACK, in, 1, 1 = NACK seen during the transfer
- oCFG_DONE, out, 1, table complete
- oBUSY, out, 1, transfer in flight
- oERR, out, 1, sticky: at least one write was skipped
- oERR_CNT, out, 8, count of skipped writes, saturating at 255

## Operation
- Reset values:
  - All outputs 0, except oI2C_DATA = {DEV_ADDR,0,0}.
  - Divider 0, state IDLE.
- States: IDLE → LOAD → SEND → WAIT → (NEXT | RETRY | SKIP) → LOAD, or → SERVE when the table is exhausted.
- Every state transition happens on a tick cycle only.
- IDLE: advances to LOAD on the first tick after reset.
- LOAD: latches oI2C_DATA from iLUT_DATA. In SERVE, it latches from the update register instead. Clears the retry counter.
- SEND: raises oI2C_GO.
- WAIT:
  - Holds oI2C_GO until iI2C_END is seen on a tick, then drops GO on that tick.
  - If iI2C_ACK = 0, go to NEXT.
  - If iI2C_ACK = 1 and retry counter < MAX_RETRY, increment the counter and go to RETRY.
  - Otherwise go to SKIP.
- RETRY: goes to SEND. oI2C_DATA is unchanged.
- SKIP: sets oERR, increments oERR_CNT (saturating), then continues as NEXT.
- NEXT:
  - If oLUT_INDEX < LUT_SIZE-1, increment the index and go to LOAD.
  - Otherwise set oCFG_DONE and go to SERVE.
  - The index never wraps.
- SERVE:
  - The update register is sampled every cycle, not only on ticks.
  - iUPD_REQ with no update pending: latch addr/data, pulse oUPD_ACK, mark pending.
  - Pending update on a tick: go to LOAD. Completion clears pending and returns to SERVE.
- Updates requested before oCFG_DONE: the request is latched the same way, but the write is deferred until the table completes.
  - A second request while one is pending gets no ACK. The requester holds its request.
- iRESTART:
  - Takes effect at any state on the next tick.
  - Drops oI2C_GO immediately.
  - Clears oCFG_DONE and the index, then goes to IDLE.
  - Does not clear oERR, oERR_CNT or a pending update.
- oBUSY = 1 in SEND, WAIT and RETRY.

## Timing
- Tick: oI2C_TICK is high for one iCLK cycle when the divider reaches CLK_FREQ/I2C_FREQ-1, after which the divider wraps to 0.
- Minimum per successful write: 4 ticks (LOAD, SEND, WAIT with END, NEXT), plus the controller's transfer time.
- oI2C_DATA is stable from LOAD until the tick on which GO drops.
- oUPD_ACK is asserted 1 cycle after iUPD_REQ is sampled high with no update pending.
- Asynchronous reset mid-transfer:
  - GO drops with no wait for END.
  - The controller is expected to be reset by the same iRST_N.

## Configuration
- CFG_WATCHDOG_EN defined:
  - WAIT also counts ticks.
  - If 1024 ticks pass with no END, GO drops and the write is treated as a NACK, i.e. it goes through the retry/skip path.
- CFG_WATCHDOG_EN undefined: WAIT waits indefinitely for END.

## Structure
- Package i2c_cfg_pkg holds:
  - state enum
  - WDOG_TICKS = 1024
  - ERR_CNT_MAX = 255
  - helper function for the divider width, computed from CLK_FREQ/I2C_FREQ
- Sub-module i2c_tick_gen (parameters CLK_FREQ and I2C_FREQ) produces oI2C_TICK.
- The sequencer FSM, retry counter and update register stay in the top level.

## Test plan
- Table path: LUT_SIZE=4, controller always ACKs → 4 writes in index order with oI2C_DATA = {8'hBA,entry}; oCFG_DONE rises after the 4th END; oERR=0.
- Retry then success: MAX_RETRY=3, entry 1 NACKs twice then ACKs → entry 1 is sent 3 times; oERR stays 0; entry 2 follows.
- Skip: entry 2 always NACKs, MAX_RETRY=3 → 4 attempts; oERR=1; oERR_CNT=1; entry 3 is still written; done still asserts.
- Updates: iUPD_REQ with addr 8'h09, data 16'h0500 during the table → ACK pulse; the write {BA,09,0500} is issued only after oCFG_DONE. A second request while pending gets no ACK until the first write completes.
- Restart: iRESTART pulsed mid-WAIT → GO low next tick; oCFG_DONE=0; index 0 is rewritten; oERR_CNT is retained.
- With CFG_WATCHDOG_EN and a controller that never asserts END → GO drops after 1024 ticks; MAX_RETRY=0 → oERR_CNT=1; sequence continues.
